// File: rtl/pipe_stage_reg_pkg.sv
// Shared types for the generic pipeline stage register: occupancy encodings
// that double as the control FSM state and the occ_out value.
package pipe_stage_reg_pkg;

  localparam int OCC_W = 2;

  typedef enum logic [OCC_W-1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/pipe_data_slot.sv
// One pipeline entry: a valid bit plus its payload, loaded or cleared as a pair.
// Load wins over clear; a cleared slot always holds an all-zero payload.
module pipe_data_slot #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d,
  output logic              valid,
  output logic [DATA_W-1:0] q
);

  // NOTE: the payload is reset as well as the valid bit, so downstream never
  // sees X on the data bus, even in cycles where valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (clear) begin
      valid <= 1'b0;
      q     <= '0;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake,
// flush-with-bubble and an optional two-entry skid that registers ready_out.
module pipe_stage_reg #(
  parameter int              DATA_W       = 64,
  parameter logic [DATA_W-1:0] FLUSH_MASK = '0,
  parameter bit              BUBBLE_VALID = 1'b1,
  parameter bit              SKID         = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n_in,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [DATA_W-1:0] data_in,
  input  logic              flush_in,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [DATA_W-1:0] data_out,
  output logic [1:0]        occ_out
);

  import pipe_stage_reg_pkg::*;

  occ_e              state;
  occ_e              state_next;
  logic              ready_r;
  logic              ready_next;
  logic              acc;
  logic              emit;
  logic              main_load;
  logic              main_clear;
  logic [DATA_W-1:0] main_d;
  logic              skid_load;
  logic              skid_clear;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_q;

  // ready_r is the registered ready with a skid; without one it only marks
  // that reset has been released, and the ready path is combinational.
  assign ready_out = SKID ? ready_r : (ready_r & (ready_in | ~valid_out));
  assign acc       = valid_in & ready_out;
  assign emit      = valid_out & ready_in;
  assign occ_out   = state;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    main_load  = 1'b0;
    main_clear = 1'b0;
    main_d     = data_in;
    skid_load  = 1'b0;
    skid_clear = 1'b0;

    if (flush_in) begin
      // A bubble keeps only the masked fields; an empty flush zeroes the slot.
      main_load  = BUBBLE_VALID;
      main_clear = !BUBBLE_VALID;
      main_d     = data_in & FLUSH_MASK;
      skid_clear = 1'b1;
      state_next = BUBBLE_VALID ? OCC_ONE : OCC_EMPTY;
    end else begin
      case (state)
        OCC_EMPTY: begin
          if (acc) begin
            main_load  = 1'b1;
            state_next = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (acc && emit) begin
            main_load = 1'b1;
          end else if (acc && SKID) begin
            skid_load  = 1'b1;
            state_next = OCC_FULL;
          end else if (emit) begin
            main_clear = 1'b1;
            state_next = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (emit && skid_valid) begin
            main_load  = 1'b1;
            main_d     = skid_q;
            skid_clear = 1'b1;
            state_next = OCC_ONE;
          end
        end
        default: begin
          main_clear = 1'b1;
          skid_clear = 1'b1;
          state_next = OCC_EMPTY;
        end
      endcase
    end

    ready_next = SKID ? (state_next != OCC_FULL) : 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state   <= OCC_EMPTY;
      ready_r <= 1'b0;
    end else begin
      state   <= state_next;
      ready_r <= ready_next;
    end
  end

  pipe_data_slot #(.DATA_W(DATA_W)) main (
    .clk   (clk),
    .rst_n (reset_n_in),
    .load  (main_load),
    .clear (main_clear),
    .d     (main_d),
    .valid (valid_out),
    .q     (data_out)
  );

  if (SKID) begin : g_skid
    pipe_data_slot #(.DATA_W(DATA_W)) skid (
      .clk   (clk),
      .rst_n (reset_n_in),
      .load  (skid_load),
      .clear (skid_clear),
      .d     (data_in),
      .valid (skid_valid),
      .q     (skid_q)
    );
  end else begin : g_no_skid
    assign skid_valid = 1'b0;
    assign skid_q     = '0;
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and scoreboard checks of pipe_stage_reg: instance a has a skid and
// valid bubbles, instance b is single-entry with empty flushes.
module tb_pipe_stage_reg;

  localparam int          W    = 64;
  localparam logic [W-1:0] MASK = 64'h0000_0000_FFFF_FFFF;

  logic         clk = 1'b0;
  logic         rst_n;
  int           total = 0;
  int           bad   = 0;

  logic         a_valid_in, a_ready_out, a_flush_in, a_valid_out, a_ready_in;
  logic [W-1:0] a_data_in, a_data_out;
  logic [1:0]   a_occ_out;
  logic         b_valid_in, b_ready_out, b_flush_in, b_valid_out, b_ready_in;
  logic [W-1:0] b_data_in, b_data_out;
  logic [1:0]   b_occ_out;

  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(W), .FLUSH_MASK(MASK), .BUBBLE_VALID(1'b1), .SKID(1'b1)) dut_a (
    .clk(clk), .reset_n_in(rst_n), .valid_in(a_valid_in), .ready_out(a_ready_out),
    .data_in(a_data_in), .flush_in(a_flush_in), .valid_out(a_valid_out),
    .ready_in(a_ready_in), .data_out(a_data_out), .occ_out(a_occ_out));

  pipe_stage_reg #(.DATA_W(W), .FLUSH_MASK(MASK), .BUBBLE_VALID(1'b0), .SKID(1'b0)) dut_b (
    .clk(clk), .reset_n_in(rst_n), .valid_in(b_valid_in), .ready_out(b_ready_out),
    .data_in(b_data_in), .flush_in(b_flush_in), .valid_out(b_valid_out),
    .ready_in(b_ready_in), .data_out(b_data_out), .occ_out(b_occ_out));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_valid_in = 1'b1; a_data_in = 64'hA5; a_ready_in = 1'b1; a_flush_in = 1'b0;
    b_valid_in = 1'b0; b_data_in = '0;     b_ready_in = 1'b1; b_flush_in = 1'b0;
    tick();
    total++; if (a_valid_out !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b want=0", a_valid_out); end
    total++; if (a_data_out !== 64'h0) begin bad++; $display("FAIL rst_data got=%h want=0", a_data_out); end
    total++; if (a_occ_out !== 2'd0) begin bad++; $display("FAIL rst_occ got=%0d want=0", a_occ_out); end
    total++; if (a_ready_out !== 1'b0) begin bad++; $display("FAIL rst_ready_a got=%0b want=0", a_ready_out); end
    total++; if (b_ready_out !== 1'b0) begin bad++; $display("FAIL rst_ready_b got=%0b want=0", b_ready_out); end
    rst_n = 1'b1;
    #1;
    total++; if (a_ready_out !== 1'b0) begin bad++; $display("FAIL rel_ready got=%0b want=0", a_ready_out); end
    tick();
    total++; if (a_ready_out !== 1'b1) begin bad++; $display("FAIL first_edge_ready got=%0b want=1", a_ready_out); end
    total++; if (a_valid_out !== 1'b0) begin bad++; $display("FAIL first_edge_valid got=%0b want=0", a_valid_out); end
    tick();
    total++; if (a_valid_out !== 1'b1 || a_data_out !== 64'hA5) begin bad++;
      $display("FAIL a5_out got=%0b/%h want=1/a5", a_valid_out, a_data_out); end
    total++; if (a_occ_out !== 2'd1) begin bad++; $display("FAIL a5_occ got=%0d want=1", a_occ_out); end
    a_valid_in = 1'b0;
    tick();
    total++; if (a_valid_out !== 1'b0 || a_data_out !== 64'h0 || a_occ_out !== 2'd0) begin bad++;
      $display("FAIL a5_drain got=%0b/%h/%0d want=0/0/0", a_valid_out, a_data_out, a_occ_out); end
  endtask

  task automatic test_stream();
    a_ready_in = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a_valid_in = 1'b1;
      a_data_in  = 64'(i);
      #1;
      total++; if (a_ready_out !== 1'b1) begin bad++; $display("FAIL stream_ready[%0d] got=%0b want=1", i, a_ready_out); end
      tick();
      total++; if (a_valid_out !== 1'b1 || a_data_out !== 64'(i)) begin bad++;
        $display("FAIL stream_out[%0d] got=%0b/%h want=1/%h", i, a_valid_out, a_data_out, 64'(i)); end
      total++; if (a_occ_out !== 2'd1) begin bad++; $display("FAIL stream_occ[%0d] got=%0d want=1", i, a_occ_out); end
    end
    a_valid_in = 1'b0;
    tick();
    total++; if (a_valid_out !== 1'b0 || a_occ_out !== 2'd0) begin bad++;
      $display("FAIL stream_end got=%0b/%0d want=0/0", a_valid_out, a_occ_out); end
  endtask

  task automatic test_skid();
    a_valid_in = 1'b1; a_data_in = 64'd5; a_ready_in = 1'b0;
    tick();
    total++; if (a_data_out !== 64'd5 || a_occ_out !== 2'd1) begin bad++;
      $display("FAIL skid_one got=%h/%0d want=5/1", a_data_out, a_occ_out); end
    a_data_in = 64'd6;
    #1;
    total++; if (a_ready_out !== 1'b1) begin bad++; $display("FAIL skid_one_ready got=%0b want=1", a_ready_out); end
    tick();
    total++; if (a_occ_out !== 2'd2 || a_ready_out !== 1'b0) begin bad++;
      $display("FAIL skid_full got=%0d/%0b want=2/0", a_occ_out, a_ready_out); end
    total++; if (a_valid_out !== 1'b1 || a_data_out !== 64'd5) begin bad++;
      $display("FAIL skid_full_out got=%0b/%h want=1/5", a_valid_out, a_data_out); end
    a_data_in = 64'd7;
    tick();
    total++; if (a_occ_out !== 2'd2 || a_data_out !== 64'd5) begin bad++;
      $display("FAIL skid_ignore got=%0d/%h want=2/5", a_occ_out, a_data_out); end
    a_valid_in = 1'b0; a_ready_in = 1'b1;
    tick();
    total++; if (a_valid_out !== 1'b1 || a_data_out !== 64'd6 || a_occ_out !== 2'd1) begin bad++;
      $display("FAIL skid_drain6 got=%0b/%h/%0d want=1/6/1", a_valid_out, a_data_out, a_occ_out); end
    total++; if (a_ready_out !== 1'b1) begin bad++; $display("FAIL skid_drain_ready got=%0b want=1", a_ready_out); end
    tick();
    total++; if (a_valid_out !== 1'b0 || a_occ_out !== 2'd0) begin bad++;
      $display("FAIL skid_empty got=%0b/%0d want=0/0", a_valid_out, a_occ_out); end
  endtask

  task automatic test_flush();
    a_valid_in = 1'b1; a_data_in = 64'd8; a_ready_in = 1'b0;
    tick();
    a_data_in = 64'd9;
    tick();
    total++; if (a_occ_out !== 2'd2) begin bad++; $display("FAIL flush_pre_occ got=%0d want=2", a_occ_out); end
    a_flush_in = 1'b1; a_data_in = 64'hDEAD_BEEF_0000_0040;
    tick();
    total++; if (a_valid_out !== 1'b1 || a_data_out !== 64'h0000_0000_0000_0040) begin bad++;
      $display("FAIL flush_bubble got=%0b/%h want=1/40", a_valid_out, a_data_out); end
    total++; if (a_occ_out !== 2'd1 || a_ready_out !== 1'b1) begin bad++;
      $display("FAIL flush_occ got=%0d/%0b want=1/1", a_occ_out, a_ready_out); end
    a_flush_in = 1'b0; a_valid_in = 1'b0; a_ready_in = 1'b1;
    tick();
    total++; if (a_valid_out !== 1'b0 || a_occ_out !== 2'd0) begin bad++;
      $display("FAIL flush_drain got=%0b/%0d want=0/0", a_valid_out, a_occ_out); end
  endtask

  task automatic test_flush_emit();
    b_valid_in = 1'b1; b_data_in = 64'h11; b_ready_in = 1'b1;
    #1;
    total++; if (b_ready_out !== 1'b1) begin bad++; $display("FAIL b_ready_empty got=%0b want=1", b_ready_out); end
    tick();
    total++; if (b_valid_out !== 1'b1 || b_data_out !== 64'h11) begin bad++;
      $display("FAIL b_load got=%0b/%h want=1/11", b_valid_out, b_data_out); end
    b_data_in = 64'h22; b_ready_in = 1'b0;
    #1;
    total++; if (b_ready_out !== 1'b0) begin bad++; $display("FAIL b_ready_stall got=%0b want=0", b_ready_out); end
    b_ready_in = 1'b1;
    #1;
    total++; if (b_ready_out !== 1'b1) begin bad++; $display("FAIL b_ready_pass got=%0b want=1", b_ready_out); end
    b_valid_in = 1'b0; b_flush_in = 1'b1;
    #1;
    total++; if (b_valid_out !== 1'b1 || b_data_out !== 64'h11) begin bad++;
      $display("FAIL b_flush_emit got=%0b/%h want=1/11", b_valid_out, b_data_out); end
    tick();
    total++; if (b_valid_out !== 1'b0 || b_data_out !== 64'h0 || b_occ_out !== 2'd0) begin bad++;
      $display("FAIL b_flush_after got=%0b/%h/%0d want=0/0/0", b_valid_out, b_data_out, b_occ_out); end
    b_flush_in = 1'b0;
  endtask

  task automatic test_async_reset();
    a_valid_in = 1'b1; a_data_in = 64'h33; a_ready_in = 1'b0;
    b_valid_in = 1'b1; b_data_in = 64'h55; b_ready_in = 1'b0;
    tick();
    b_valid_in = 1'b0;
    a_data_in  = 64'h44;
    tick();
    total++; if (a_occ_out !== 2'd2 || b_valid_out !== 1'b1) begin bad++;
      $display("FAIL arst_pre got=%0d/%0b want=2/1", a_occ_out, b_valid_out); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (a_valid_out !== 1'b0 || a_ready_out !== 1'b0 || a_data_out !== 64'h0) begin bad++;
      $display("FAIL arst_a got=%0b/%0b/%h want=0/0/0", a_valid_out, a_ready_out, a_data_out); end
    total++; if (a_occ_out !== 2'd0) begin bad++; $display("FAIL arst_occ got=%0d want=0", a_occ_out); end
    total++; if (b_valid_out !== 1'b0 || b_ready_out !== 1'b0 || b_data_out !== 64'h0) begin bad++;
      $display("FAIL arst_b got=%0b/%0b/%h want=0/0/0", b_valid_out, b_ready_out, b_data_out); end
    a_valid_in = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic a_hold = 1'b0;
    logic b_hold = 1'b0;
    logic exp_rdy, exp_vld, acc, emit;
    logic [W-1:0] exp_dat;
    qa.delete();
    qb.delete();
    rst_n = 1'b1;
    tick();
    for (int c = 0; c < 10000; c++) begin
      if (!a_hold) begin a_valid_in = ($urandom_range(0, 9) < 7); a_data_in = {$urandom, $urandom}; end
      if (!b_hold) begin b_valid_in = ($urandom_range(0, 9) < 7); b_data_in = {$urandom, $urandom}; end
      a_ready_in = ($urandom_range(0, 9) < 6);
      b_ready_in = ($urandom_range(0, 9) < 6);
      #1;
      exp_rdy = (qa.size() < 2);
      exp_vld = (qa.size() != 0);
      exp_dat = exp_vld ? qa[0] : '0;
      total++; if (a_ready_out !== exp_rdy || a_valid_out !== exp_vld || a_data_out !== exp_dat ||
                   a_occ_out !== 2'(qa.size())) begin bad++;
        $display("FAIL rand_a[%0d] got=%0b/%0b/%h/%0d want=%0b/%0b/%h/%0d", c, a_ready_out, a_valid_out,
                 a_data_out, a_occ_out, exp_rdy, exp_vld, exp_dat, qa.size()); end
      acc  = a_valid_in & exp_rdy;
      emit = exp_vld & a_ready_in;
      if (emit) void'(qa.pop_front());
      if (acc) qa.push_back(a_data_in);
      a_hold = a_valid_in & !acc;

      exp_vld = (qb.size() != 0);
      exp_rdy = b_ready_in | !exp_vld;
      exp_dat = exp_vld ? qb[0] : '0;
      total++; if (b_ready_out !== exp_rdy || b_valid_out !== exp_vld || b_data_out !== exp_dat ||
                   b_occ_out !== 2'(qb.size())) begin bad++;
        $display("FAIL rand_b[%0d] got=%0b/%0b/%h/%0d want=%0b/%0b/%h/%0d", c, b_ready_out, b_valid_out,
                 b_data_out, b_occ_out, exp_rdy, exp_vld, exp_dat, qb.size()); end
      acc  = b_valid_in & exp_rdy;
      emit = exp_vld & b_ready_in;
      if (emit) void'(qb.pop_front());
      if (acc) qb.push_back(b_data_in);
      b_hold = b_valid_in & !acc;

      tick();
      if (bad > 20) break;
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_skid();
    test_flush();
    test_flush_emit();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
